// File: rtl/ddr_pkg.sv
// ddr_pkg: constants and types shared by the DDR read engine.
//   AXI4 encodings used on the AR/R channels, the 4 KB page size that
//   bursts must not cross, and the read engine FSM state encoding.
package ddr_pkg;

  localparam logic [2:0] ARSIZE_8B  = 3'd3;    // 8 bytes per beat
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // A burst may not cross a 4 KB page. Beats are 8 bytes, so a page
  // holds 512 beats.
  localparam int         PAGE_BYTES = 4096;
  localparam logic [9:0] PAGE_WORDS = 10'(PAGE_BYTES / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_CPL  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/ddr_burst_split.sv
// ddr_burst_split: combinational burst sizing for the DDR read engine.
//   beats = min(remaining, P_MAX_BURST_LEN, words left in the 4 KB page)
// Ports:
//   word_off  in  9   byte address bits [11:3] (8-byte word offset in page)
//   remaining in  16  words still to request for the descriptor
//   beats     out 9   beats in the next burst (1..256 when remaining > 0)
//   arlen     out 8   beats - 1, ready for m_axi_arlen
module ddr_burst_split
  import ddr_pkg::*;
#(
  parameter int P_MAX_BURST_LEN = 16
) (
  input  logic [8:0]  word_off,
  input  logic [15:0] remaining,
  output logic [8:0]  beats,
  output logic [7:0]  arlen
);

  localparam logic [15:0] MAX_BEATS = 16'(P_MAX_BURST_LEN);

  logic [9:0] page_beats;
  logic [8:0] rem_clip;

  always_comb begin
    // Offset 0 gives 512, which never wins the compare because rem_clip
    // is already limited to at most 256.
    page_beats = PAGE_WORDS - {1'b0, word_off};
    rem_clip   = (remaining > MAX_BEATS) ? MAX_BEATS[8:0] : remaining[8:0];
    beats      = ({1'b0, rem_clip} > page_beats) ? page_beats[8:0] : rem_clip;
    // 256 beats wraps to 8'hFF, which is the correct arlen.
    arlen      = beats[7:0] - 8'd1;
  end

endmodule

// File: rtl/ddr_rd_engine.sv
// ddr_rd_engine: consumer of one DDR local-queue read descriptor at a time.
//   Splits the descriptor into AXI4 INCR bursts (one outstanding), forwards
//   the returned data as a single AXI-Stream packet and pulses o_rd_ddr_cpl
//   together with o_rd_ddr_ready once the final beat has left the engine.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_rd_ddr_*               descriptor in (addr, len in 64-bit words, strb)
//   o_rd_ddr_ready/cpl       idle indication / one-cycle completion pulse
//   m_axi_ar* / m_axi_r*     AXI4 read address and read data channels
//   m_axis_t*                AXI-Stream packet out, one output register stage
//   o_rd_err                 one-cycle pulse per bad R beat (resp or rlast)
module ddr_rd_engine
  import ddr_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int P_AXI_ID           = 0,
  parameter int P_MAX_BURST_LEN    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_ddr_addr,
  input  logic [15:0]                   i_rd_ddr_len,
  input  logic [7:0]                    i_rd_ddr_strb,
  input  logic                          i_rd_ddr_valid,
  output logic                          o_rd_ddr_ready,
  output logic                          o_rd_ddr_cpl,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          o_rd_err
);

  rd_state_t                     state_reg;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_reg;   // address of the next burst
  logic [15:0]                   rem_reg;    // words not yet requested
  logic [7:0]                    strb_reg;
  logic [8:0]                    bcnt_reg;   // beats left in current burst
  logic                          ready_reg;
  logic                          cpl_reg;
  logic                          err_reg;
  logic                          arvalid_reg;
  logic [7:0]                    arlen_reg;
  logic                          tvalid_reg;
  logic [C_M_AXI_DATA_WIDTH-1:0] tdata_reg;
  logic [7:0]                    tkeep_reg;
  logic                          tlast_reg;

  logic [8:0]  split_word;
  logic [15:0] split_rem;
  logic [8:0]  split_beats;
  logic [7:0]  split_arlen;
  logic        rready;
  logic        r_fire;
  logic        last_beat;

  // In IDLE the first burst is sized straight from the descriptor so that
  // arvalid can rise the cycle after accept; afterwards from the live state.
  assign split_word = (state_reg == ST_IDLE) ? i_rd_ddr_addr[11:3] : addr_reg[11:3];
  assign split_rem  = (state_reg == ST_IDLE) ? i_rd_ddr_len : rem_reg;

  ddr_burst_split #(
    .P_MAX_BURST_LEN (P_MAX_BURST_LEN)
  ) u_split (
    .word_off  (split_word),
    .remaining (split_rem),
    .beats     (split_beats),
    .arlen     (split_arlen)
  );

  // Accept a beat whenever the output register is empty or draining.
  assign rready    = (state_reg == ST_DATA) && (!tvalid_reg || m_axis_tready);
  assign r_fire    = m_axi_rvalid && rready;
  assign last_beat = (rem_reg == 16'd0) && (bcnt_reg == 9'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      rem_reg     <= '0;
      strb_reg    <= '0;
      bcnt_reg    <= '0;
      ready_reg   <= 1'b0;
      cpl_reg     <= 1'b0;
      err_reg     <= 1'b0;
      arvalid_reg <= 1'b0;
      arlen_reg   <= '0;
      tvalid_reg  <= 1'b0;
      tdata_reg   <= '0;
      tkeep_reg   <= '0;
      tlast_reg   <= 1'b0;
    end else begin
      cpl_reg <= 1'b0;
      err_reg <= 1'b0;
      if (tvalid_reg && m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          // During the cpl cycle the queue still shows the descriptor it is
          // about to pop, so it must not be taken a second time.
          if (ready_reg && i_rd_ddr_valid && !cpl_reg) begin
            ready_reg <= 1'b0;
            addr_reg  <= i_rd_ddr_addr;
            rem_reg   <= i_rd_ddr_len;
            strb_reg  <= i_rd_ddr_strb;
            if (i_rd_ddr_len == 16'd0) begin
              state_reg <= ST_CPL;
            end else begin
              state_reg   <= ST_AR;
              arvalid_reg <= 1'b1;
              arlen_reg   <= split_arlen;
            end
          end else begin
            ready_reg <= 1'b1;
          end
        end

        ST_AR: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            addr_reg    <= addr_reg + C_M_AXI_ADDR_WIDTH'({split_beats, 3'b000});
            rem_reg     <= rem_reg - 16'(split_beats);
            bcnt_reg    <= split_beats;
            state_reg   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (r_fire) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= m_axi_rdata;
            tlast_reg  <= last_beat;
            tkeep_reg  <= last_beat ? strb_reg : 8'hFF;
            bcnt_reg   <= bcnt_reg - 9'd1;
            // Framing follows our own beat count; a bad response or a
            // misplaced rlast is only flagged.
            if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != (bcnt_reg == 9'd1))) begin
              err_reg <= 1'b1;
            end
            if (bcnt_reg == 9'd1) begin
              if (rem_reg != 16'd0) begin
                state_reg   <= ST_AR;
                arvalid_reg <= 1'b1;
                arlen_reg   <= split_arlen;
              end else begin
                state_reg <= ST_CPL;
              end
            end
          end
        end

        ST_CPL: begin
          if (!tvalid_reg || (m_axis_tready && tlast_reg)) begin
            cpl_reg   <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_ddr_ready = ready_reg;
  assign o_rd_ddr_cpl   = cpl_reg;
  assign o_rd_err       = err_reg;
  assign m_axi_arid     = C_M_AXI_ID_WIDTH'(P_AXI_ID);
  assign m_axi_araddr   = addr_reg;
  assign m_axi_arlen    = arlen_reg;
  assign m_axi_arsize   = ARSIZE_8B;
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arvalid  = arvalid_reg;
  assign m_axi_rready   = rready;
  assign m_axis_tdata   = tdata_reg;
  assign m_axis_tkeep   = tkeep_reg;
  assign m_axis_tlast   = tlast_reg;
  assign m_axis_tvalid  = tvalid_reg;

endmodule

// File: tb/tb_ddr_rd_engine.sv
// tb_ddr_rd_engine: directed bench for ddr_rd_engine.
//   A simple AXI4 read slave answers bursts with address-derived data; a
//   monitor logs stream beats, AR handshakes, cpl and err pulses; the main
//   initial block runs the descriptors and compares against hand values.
module tb_ddr_rd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d_addr  = '0;
  logic [15:0] d_len   = '0;
  logic [7:0]  d_strb  = '0;
  logic        d_valid = 1'b0;
  logic        ready, cpl, err;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic [63:0] rdata   = '0;
  logic [1:0]  rresp   = '0;
  logic        rlast   = 1'b0;
  logic        rvalid  = 1'b0;
  logic        tready  = 1'b0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid;

  int total = 0;
  int bad   = 0;

  logic ar_rand   = 1'b0;
  logic r_rand    = 1'b0;
  logic tr_toggle = 1'b0;
  int   err_at    = -1;

  ddr_rd_engine #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (64),
    .C_M_AXI_ID_WIDTH   (1),
    .P_AXI_ID           (0),
    .P_MAX_BURST_LEN    (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rd_ddr_addr  (d_addr),
    .i_rd_ddr_len   (d_len),
    .i_rd_ddr_strb  (d_strb),
    .i_rd_ddr_valid (d_valid),
    .o_rd_ddr_ready (ready),
    .o_rd_ddr_cpl   (cpl),
    .m_axi_arid     (arid),
    .m_axi_araddr   (araddr),
    .m_axi_arlen    (arlen),
    .m_axi_arsize   (arsize),
    .m_axi_arburst  (arburst),
    .m_axi_arvalid  (arvalid),
    .m_axi_arready  (arready),
    .m_axi_rdata    (rdata),
    .m_axi_rresp    (rresp),
    .m_axi_rlast    (rlast),
    .m_axi_rvalid   (rvalid),
    .m_axi_rready   (rready),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tlast   (tlast),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .o_rd_err       (err)
  );

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'hC0DEF00D, a};
  endfunction

  // AXI read slave + stream sink ready. Samples handshakes at negedge,
  // drives new values 1 ns after posedge.
  logic [31:0] s_addr = '0;
  int          s_left = 0;
  int          s_idx  = 0;
  int          r_total = 0;
  logic        ar_hs, r_hs;
  logic [31:0] ar_cap_addr;
  logic [7:0]  ar_cap_len;

  always begin
    @(negedge clk);
    ar_hs       = arvalid && arready;
    r_hs        = rvalid && rready;
    ar_cap_addr = araddr;
    ar_cap_len  = arlen;
    @(posedge clk);
    #1;
    if (rst) begin
      s_left  = 0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
    end else begin
      if (r_hs) begin
        s_idx++;
        s_left--;
        r_total++;
      end
      if (ar_hs) begin
        s_addr = ar_cap_addr;
        s_idx  = 0;
        s_left = int'(ar_cap_len) + 1;
      end
      arready = (s_left == 0) && (!ar_rand || $urandom_range(0, 1) == 1);
      if (!(rvalid && !r_hs)) begin
        if (s_left > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
          rvalid = 1'b1;
          rdata  = data_of(s_addr + 32'(s_idx * 8));
          rlast  = (s_left == 1);
          rresp  = (r_total == err_at) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          rresp  = 2'b00;
        end
      end
    end
    tready = tr_toggle ? !tready : 1'b1;
  end

  // Monitor
  logic [63:0] got_data[$];
  logic [7:0]  got_keep[$];
  logic        got_last[$];
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  int cyc = 0, cpl_cnt = 0, err_cnt = 0, cpl_bad = 0, tlast_cyc = 0, cpl_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (tvalid && tready) begin
      got_data.push_back(tdata);
      got_keep.push_back(tkeep);
      got_last.push_back(tlast);
      if (tlast) tlast_cyc = cyc;
    end
    if (arvalid && arready) begin
      ar_addr_log.push_back(araddr);
      ar_len_log.push_back(arlen);
    end
    if (cpl) begin
      cpl_cnt++;
      cpl_cyc = cyc;
      if (!ready) cpl_bad++;
    end
    if (err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input string tag, input logic [31:0] a,
                           input logic [15:0] l, input logic [7:0] s);
    bit acc;
    d_addr  = a;
    d_len   = l;
    d_strb  = s;
    d_valid = 1'b1;
    acc     = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (ready && !cpl) acc = 1'b1;
      step();
    end
    d_valid = 1'b0;
    chk({tag, " accept"}, 64'(acc), 64'd1);
    chk({tag, " ready drop"}, 64'(ready), 64'd0);
  endtask

  task automatic run_desc(input string tag, input logic [31:0] a,
                          input logic [15:0] l, input logic [7:0] s);
    int b_beat, b_ar, b_cpl, n;
    bit done;
    b_beat = got_data.size();
    b_ar   = ar_addr_log.size();
    b_cpl  = cpl_cnt;
    send_desc(tag, a, l, s);
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (cpl_cnt != b_cpl) done = 1'b1;
    end
    chk({tag, " cpl seen"}, 64'(done), 64'd1);
    step();
    step();
    chk({tag, " cpl count"}, 64'(cpl_cnt - b_cpl), 64'd1);
    chk({tag, " cpl with ready"}, 64'(cpl_bad), 64'd0);
    n = got_data.size() - b_beat;
    chk({tag, " beat count"}, 64'(n), 64'(l));
    for (int k = 0; k < n && k < int'(l); k++) begin
      chk($sformatf("%s beat%0d data", tag, k), got_data[b_beat + k], data_of(a + 32'(k * 8)));
      chk($sformatf("%s beat%0d keep", tag, k), 64'(got_keep[b_beat + k]),
          (k == int'(l) - 1) ? 64'(s) : 64'hFF);
      chk($sformatf("%s beat%0d last", tag, k), 64'(got_last[b_beat + k]),
          (k == int'(l) - 1) ? 64'd1 : 64'd0);
    end
    if (l != 16'd0) chk({tag, " cpl after tlast"}, 64'(cpl_cyc > tlast_cyc), 64'd1);
    chk({tag, " ar count"}, 64'(ar_addr_log.size() - b_ar), 64'(exp_ar_addr.size()));
    for (int k = 0; k < exp_ar_addr.size() && b_ar + k < ar_addr_log.size(); k++) begin
      chk($sformatf("%s ar%0d addr", tag, k), 64'(ar_addr_log[b_ar + k]), 64'(exp_ar_addr[k]));
      chk($sformatf("%s ar%0d len", tag, k), 64'(ar_len_log[b_ar + k]), 64'(exp_ar_len[k]));
    end
  endtask

  initial begin
    int b_beat, b_ar, b_cpl, b_err;

    // reset state
    step();
    step();
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst arvalid", 64'(arvalid), 64'd0);
    chk("rst rready", 64'(rready), 64'd0);
    chk("rst tvalid", 64'(tvalid), 64'd0);
    chk("rst cpl", 64'(cpl), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("arsize", 64'(arsize), 64'd3);
    chk("arburst", 64'(arburst), 64'd1);
    chk("arid", 64'(arid), 64'd0);
    rst = 1'b0;
    step();
    chk("ready after release", 64'(ready), 64'd1);

    // single burst, partial last word
    exp_ar_addr = '{32'h100};
    exp_ar_len  = '{8'd9};
    run_desc("t1", 32'h100, 16'd10, 8'h0F);

    // 4 KB boundary split
    exp_ar_addr = '{32'hFF0, 32'h1000};
    exp_ar_len  = '{8'd1, 8'd5};
    run_desc("t2", 32'hFF0, 16'd8, 8'h3C);

    // max-burst split
    exp_ar_addr = '{32'h0, 32'h80, 32'h100};
    exp_ar_len  = '{8'd15, 8'd15, 8'd7};
    run_desc("t3", 32'h0, 16'd40, 8'h01);

    // backpressure and random R/AR timing
    ar_rand = 1'b1;
    r_rand = 1'b1;
    tr_toggle = 1'b1;
    exp_ar_addr = '{32'h2000};
    exp_ar_len  = '{8'd11};
    run_desc("t4", 32'h2000, 16'd12, 8'hF0);
    ar_rand = 1'b0;
    r_rand = 1'b0;
    tr_toggle = 1'b0;
    step();
    step();

    // error response on beat 3
    b_err  = err_cnt;
    err_at = r_total + 2;
    exp_ar_addr = '{32'h3000};
    exp_ar_len  = '{8'd4};
    run_desc("t5", 32'h3000, 16'd5, 8'h7F);
    err_at = -1;
    chk("t5 err pulses", 64'(err_cnt - b_err), 64'd1);

    // zero-length descriptor
    b_beat = got_data.size();
    b_ar   = ar_addr_log.size();
    b_cpl  = cpl_cnt;
    send_desc("t6", 32'h3800, 16'd0, 8'hFF);
    for (int i = 0; i < 3 && !cpl; i++) step();
    chk("t6 cpl pulse", 64'(cpl), 64'd1);
    chk("t6 ready with cpl", 64'(ready), 64'd1);
    step();
    chk("t6 cpl one cycle", 64'(cpl), 64'd0);
    chk("t6 cpl count", 64'(cpl_cnt - b_cpl), 64'd1);
    chk("t6 no ar", 64'(ar_addr_log.size() - b_ar), 64'd0);
    chk("t6 no beats", 64'(got_data.size() - b_beat), 64'd0);

    // reset during DATA
    b_beat = got_data.size();
    b_cpl  = cpl_cnt;
    send_desc("t7", 32'h4000, 16'd20, 8'hFF);
    for (int i = 0; i < 500 && got_data.size() < b_beat + 5; i++) step();
    chk("t7 beats before reset", 64'(got_data.size() >= b_beat + 5), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t7 rst ready", 64'(ready), 64'd0);
    chk("t7 rst arvalid", 64'(arvalid), 64'd0);
    chk("t7 rst rready", 64'(rready), 64'd0);
    chk("t7 rst tvalid", 64'(tvalid), 64'd0);
    chk("t7 rst cpl", 64'(cpl), 64'd0);
    chk("t7 rst err", 64'(err), 64'd0);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("t7 ready after release", 64'(ready), 64'd1);
    chk("t7 no cpl", 64'(cpl_cnt - b_cpl), 64'd0);
    exp_ar_addr = '{32'h5000};
    exp_ar_len  = '{8'd1};
    run_desc("t7b", 32'h5000, 16'd2, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_rd_engine.md
Name: ddr_rd_engine

Overview:
Consumer side of the DDR local-queue read descriptor interface. Accepts one read descriptor (addr, len in 64-bit words, last-word byte strobe), splits it into AXI4 INCR read bursts, and forwards the returned data as one AXI-Stream packet. Signals per-descriptor completion back to the queue so the queue can pop its next descriptor. Sits between ddr_local_queue and the DDR AXI4 master port, one instance per local queue.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 64, AXI/stream data width; fixed at 64 (len counts 8-byte words)
C_M_AXI_ID_WIDTH, 1, ARID width
P_AXI_ID, 0, constant ARID value
P_MAX_BURST_LEN, 16, max beats per AR burst (1..256)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_rd_ddr_addr  in  C_M_AXI_ADDR_WIDTH  descriptor byte address, 8-byte aligned
i_rd_ddr_len  in  16  descriptor length in 64-bit words
i_rd_ddr_strb  in  8  byte-valid mask of final word
i_rd_ddr_valid  in  1  descriptor valid
o_rd_ddr_ready  out  1  engine idle, can accept descriptor
o_rd_ddr_cpl  out  1  one-cycle pulse: descriptor fully delivered
m_axi_arid  out  C_M_AXI_ID_WIDTH  = P_AXI_ID
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant 3'd3
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  64  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  64  packet data
m_axis_tkeep  out  8  byte keep
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
o_rd_err  out  1  one-cycle pulse on error beat

Behaviour:
- Reset: all outputs 0 (o_rd_ddr_ready 0, arvalid 0, rready 0, tvalid 0, cpl 0, err 0); FSM to IDLE. Reset mid-burst abandons the descriptor, no cpl.
- FSM IDLE/AR/DATA/CPL.
- IDLE: o_rd_ddr_ready=1 (from first clock after reset release). Handshake on valid&ready: latch addr, len, strb; remaining=len; ready drops next cycle. len==0 -> CPL directly, no AR, no stream beat.
- AR: arvalid asserted the cycle after descriptor accept. beats = min(remaining, P_MAX_BURST_LEN, (4096 - addr[11:0])>>3); arlen=beats-1; araddr/arlen held stable until arready. On arvalid&arready -> DATA, addr += beats<<3, remaining -= beats. One outstanding burst only.
- DATA: one output register stage; rready = !tvalid | tready (no beat lost or duplicated). Each R beat loads tdata; burst beat counter decrements. Final beat of descriptor (remaining==0 and burst counter==1): tlast=1, tkeep=latched strb; all other beats tkeep=8'hFF, tlast=0. End of burst: remaining>0 -> AR; else -> CPL.
- rresp!=OKAY or rlast disagreeing with beat counter -> o_rd_err pulse that cycle; data still forwarded, beat counter (not rlast) governs framing.
- CPL: wait until output register drained (tvalid=0 or tvalid&tready&tlast); then o_rd_ddr_cpl=1 for exactly one cycle, coincident with o_rd_ddr_ready returning to 1, FSM -> IDLE. Queue samples cpl&ready, so both must be high together.
- Widths: remaining 16 bit; 4KB-boundary beats 10 bit; beats compare unsigned.

Decomposition:
- Shared package ddr_pkg: AXI constants (ARSIZE_8B=3, BURST_INCR=2'b01, RESP_OKAY=2'b00), 4KB page constant, FSM state encoding.
- Optional sub-module ddr_burst_split (combinational beats/arlen calculation from addr, remaining, P_MAX_BURST_LEN); rest in one module.

Test Plan:
- addr 0x100, len 10, strb 0x0F, P_MAX_BURST_LEN 16 -> one AR arlen 9; 10 stream beats, beat 10 tlast=1 tkeep=0x0F; one cpl pulse with ready high.
- addr 0x0FF0, len 8 -> AR araddr 0x0FF0 arlen 1, then 0x1000 arlen 5; single packet of 8 beats, one tlast.
- addr 0x0, len 40 -> bursts arlen 15,15,7 at 0x0,0x80,0x100; 40 beats, cpl once after last tready.
- len 12, tready toggling 1/0 every cycle, rvalid random -> output data sequence equals rdata sequence, no drop/dup; cpl only after tlast accepted.
- beat 3 of len 5 with rresp=2'b10 -> o_rd_err one pulse; still 5 beats, tlast on beat 5; len 0 descriptor -> cpl 1 cycle after accept, no AR.
- i_rst asserted during DATA of len 20 -> all outputs 0 immediately, no cpl; next descriptor len 2 after release completes normally.
